// File: rtl/stack_ctrl.sv
// CALL/RET sequencer driving the return-address stack memory.
// Define STACK_CTRL_GUARD_EN to enable full/empty checks and sticky error flags.
module stack_ctrl #(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic [DW-1:0] ret_addr,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_addr,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [DW-1:0] stk_wdata,
    input  logic [DW-1:0] stk_rdata,
    output logic [AW:0]   depth,
    output logic          err_overflow,
    output logic          err_underflow,
    input  logic          err_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          ready_q, push_q, pop_q, rsp_valid_q;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rsp_addr_q, rsp_addr_d;
    logic [AW:0]   depth_q, depth_d;
    logic          full, empty;
    logic          ov_set, un_set;

`ifdef STACK_CTRL_GUARD_EN
    assign full  = (depth_q == (AW+1)'(DEPTH));
    assign empty = (depth_q == '0);
`else
    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        rsp_addr_d = rsp_addr_q;
        depth_d    = depth_q;
        ov_set     = 1'b0;
        un_set     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // ready_q is low only until the first edge after reset
                if (ready_q && call_req) begin
                    if (full) begin
                        ov_set = 1'b1;
                    end else begin
                        wdata_d = ret_addr;
                        state_d = S_PUSH;
                    end
                end else if (ready_q && ret_req) begin
                    if (empty) begin
                        un_set     = 1'b1;
                        rsp_addr_d = '0;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_POP;
                    end
                end
            end
            S_PUSH: begin
                depth_d = depth_q + (AW+1)'(1);
                state_d = S_IDLE;
            end
            S_POP: begin
                depth_d = depth_q - (AW+1)'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                rsp_addr_d = stk_rdata;
                state_d    = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            wdata_q     <= '0;
            rsp_addr_q  <= '0;
            depth_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == S_IDLE);
            push_q      <= (state_d == S_PUSH);
            pop_q       <= (state_d == S_POP);
            rsp_valid_q <= (state_d == S_RESP);
            wdata_q     <= wdata_d;
            rsp_addr_q  <= rsp_addr_d;
            depth_q     <= depth_d;
        end
    end

`ifdef STACK_CTRL_GUARD_EN
    logic ov_q, un_q;

    // a same-cycle clear wins over a new error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_q <= 1'b0;
            un_q <= 1'b0;
        end else if (err_clr) begin
            ov_q <= 1'b0;
            un_q <= 1'b0;
        end else begin
            ov_q <= ov_q | ov_set;
            un_q <= un_q | un_set;
        end
    end

    assign err_overflow  = ov_q;
    assign err_underflow = un_q;
`else
    logic unused_guard;
    assign unused_guard  = err_clr ^ ov_set ^ un_set;
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_wdata = wdata_q;
    assign depth     = depth_q;

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

CALL/RET sequencer that drives the stack memory on behalf of the KGP-RISC control unit. It accepts call and return requests through a ready/valid handshake and issues single-cycle push and pop strobes with write data to the stack. It captures the registered pop data and hands the return address back to the fetch stage. It also tracks stack occupancy and flags overflow and underflow.

## Interface
- DW, 32, data/address width
- DEPTH, 64, stack entries; must equal the stack memory depth
- AW, 6, log2(DEPTH)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; also drives the stack memory reset
- call_req  in  1  push request; accepted when call_req & req_ready
- ret_req  in  1  pop request; accepted when ret_req & req_ready & ~call_req
- ret_addr  in  DW  return address to push; sampled at call acceptance
- req_ready  out  1  high only in IDLE
- rsp_valid  out  1  one-cycle pulse; rsp_addr valid
- rsp_addr  out  DW  popped return address
- stk_push  out  1  to stack push
- stk_pop  out  1  to stack pop
- stk_wdata  out  DW  to stack data_in
- stk_rdata  in  DW  from stack data_out; valid the cycle after stk_pop is sampled
- depth  out  AW+1  current occupancy, 0..DEPTH
- err_overflow  out  1  sticky; cleared by err_clr or reset
- err_underflow  out  1  sticky; cleared by err_clr or reset
- err_clr  in  1  synchronous clear of both error flags

## Operation
- FSM states: IDLE, PUSH, POP, WAIT, RESP. Reset state is IDLE.
- IDLE: req_ready=1.
  - call_req with depth<DEPTH: latch ret_addr, go to PUSH.
  - ret_req (no call_req) with depth>0: go to POP.
  - Priority: call over ret. A held ret_req is accepted on the next IDLE cycle.
- PUSH: stk_push=1, stk_wdata=latched address. At cycle end, depth+1. Go to IDLE.
- POP: stk_pop=1. At cycle end, depth-1. Go to WAIT.
- WAIT: rsp_addr<=stk_rdata at cycle end. Go to RESP.
- RESP: rsp_valid=1. Go to IDLE.
- stk_push and stk_pop are never high in the same cycle. Both are 0 outside PUSH/POP.
- Full case (call_req with depth==DEPTH): request consumed, no push, err_overflow<=1, stay IDLE.
- Empty case (ret_req with depth==0): request consumed, no pop, err_underflow<=1, rsp_addr<=0, go to RESP (rsp_valid pulses so fetch never hangs).
- err_clr has priority over a same-cycle error set: the flag ends at 0.
- Reset mid-operation: immediate return to IDLE, in-flight request discarded, depth=0. The stack pointer is cleared by the same reset, so the two stay aligned.

## Timing
- Reset values: req_ready=0 while reset is asserted, 1 in the first cycle after release. rsp_valid=0, rsp_addr=0, stk_push=0, stk_pop=0, stk_wdata=0, depth=0, err_overflow=0, err_underflow=0.
- Call: accept at cycle N; stk_push high in N+1; depth updated and req_ready high in N+2. Throughput is one call per 2 cycles.
- Ret: accept at N; stk_pop high in N+1; stk_rdata valid in N+2; rsp_valid in N+3; req_ready high in N+4.
- Underflow ret: accept at N; rsp_valid with rsp_addr=0 in N+1.
- Overflow call: flag visible in N+1; req_ready stays high.
- Outputs are all registered. No combinational path from inputs to outputs except req_ready, which decodes from state only.

## Configuration
- STACK_CTRL_GUARD_EN defined:
  - full/empty checks active.
  - error flags behave as above.
- STACK_CTRL_GUARD_EN undefined:
  - No full/empty checks; every request issues push/pop.
  - depth wraps modulo 2^(AW+1).
  - err_overflow and err_underflow are tied to 0.
  - err_clr is ignored.

## Test plan
- Reset then three calls with ret_addr 0x100, 0x104, 0x108 -> three stk_push pulses 2 cycles apart with matching stk_wdata; depth=3.
- Three rets after the above -> rsp_addr 0x108, 0x104, 0x100 in order; each rsp_valid 3 cycles after acceptance; depth=0.
- call_req and ret_req high together in IDLE with depth=1 -> push first, then pop accepted on the next IDLE; depth ends at 1.
- 64 calls then a 65th (guard enabled) -> no 65th push, err_overflow=1, depth=64. Assert err_clr -> flag cleared.
- ret at depth=0 (guard enabled) -> no stk_pop, rsp_valid with rsp_addr=0 one cycle after acceptance, err_underflow=1.
- Reset asserted during WAIT after 2 calls and 1 ret -> all outputs 0 asynchronously; no rsp_valid; depth=0 after release.
